// File: rtl/heap_cmd_issuer.sv
// heap_cmd_issuer: serialises push/pop commands onto heap_control, one in flight,
// resolving NOP/illegal/underflow/overflow locally. Optional WAIT watchdog: HEAP_CMD_TIMEOUT_EN.
module heap_cmd_issuer #(
   parameter int KEY_W          = 32,
   parameter int N_W            = 10,
   parameter int DEPTH          = 1023,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [KEY_W-1:0] cmd_key,
   output logic             hp_start,
   output logic [1:0]       hp_instruction,
   output logic [KEY_W-1:0] hp_key,
   input  logic             hp_done,
   input  logic [KEY_W-1:0] hp_arr_out,
   input  logic [N_W-1:0]   hp_n,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [KEY_W-1:0] rsp_data,
   output logic [1:0]       rsp_code,
   output logic [N_W-1:0]   rsp_n
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_PUSH  = 2'b01;
   localparam logic [1:0] OP_POP   = 2'b10;
   localparam logic [1:0] OP_ILL   = 2'b11;
   localparam logic [1:0] CODE_OK  = 2'b00;
   localparam logic [1:0] CODE_REJ = 2'b01;
   localparam logic [1:0] CODE_ILL = 2'b10;
   localparam logic [1:0] CODE_TMO = 2'b11;

   state_t             state_r, state_s;
   logic [1:0]         op_r, op_s;
   logic [KEY_W-1:0]   key_r, key_s;
   logic               run_r;
   logic               hp_start_r, hp_start_s;
   logic [1:0]         hp_instr_r, hp_instr_s;
   logic [KEY_W-1:0]   hp_key_r, hp_key_s;
   logic               rsp_valid_r, rsp_valid_s;
   logic [KEY_W-1:0]   rsp_data_r, rsp_data_s;
   logic [1:0]         rsp_code_r, rsp_code_s;
   logic [N_W-1:0]     rsp_n_r, rsp_n_s;
   logic               cmd_ready_s;
   logic               timeout_s;
   logic               in_flight_s;

`ifdef HEAP_CMD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_r;

   // WAIT-cycle counter, zero whenever the FSM is outside WAIT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt_r <= '0;
      end else if (state_r != ST_WAIT) begin
         wait_cnt_r <= '0;
      end else begin
         wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end
   end

   assign timeout_s = (state_r == ST_WAIT) && (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   // No watchdog: WAIT holds until the controller answers.
   logic unused_timeout_cfg_s;
   assign unused_timeout_cfg_s = (TIMEOUT_CYCLES > 0);
   assign timeout_s            = 1'b0;
`endif

   // run_r keeps cmd_ready low until the first edge after reset release
   assign cmd_ready_s = run_r && (state_r == ST_IDLE) && !hp_done;

   // Next-state and next-output computation
   always_comb begin
      state_s     = state_r;
      op_s        = op_r;
      key_s       = key_r;
      rsp_data_s  = rsp_data_r;
      rsp_code_s  = rsp_code_r;
      rsp_n_s     = rsp_n_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_s) begin
               op_s       = cmd_op;
               key_s      = cmd_key;
               rsp_data_s = '0;
               rsp_n_s    = hp_n;
               rsp_code_s = CODE_OK;
               case (cmd_op)
                  OP_NOP: begin
                     state_s = ST_RESP;
                  end
                  OP_PUSH: begin
                     if (hp_n == N_W'(DEPTH)) begin
                        state_s    = ST_RESP;
                        rsp_code_s = CODE_REJ;
                     end else begin
                        state_s = ST_ISSUE;
                     end
                  end
                  OP_POP: begin
                     if (hp_n == '0) begin
                        state_s    = ST_RESP;
                        rsp_code_s = CODE_REJ;
                     end else begin
                        state_s = ST_ISSUE;
                     end
                  end
                  OP_ILL: begin
                     state_s    = ST_RESP;
                     rsp_code_s = CODE_ILL;
                  end
                  default: begin
                     state_s    = ST_RESP;
                     rsp_code_s = CODE_ILL;
                  end
               endcase
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // a done coinciding with start is deliberately not looked at here
            state_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (hp_done) begin
               state_s    = ST_RESP;
               rsp_code_s = CODE_OK;
               rsp_n_s    = hp_n;
               if (op_r == OP_POP) begin
                  rsp_data_s = hp_arr_out;
               end else begin
                  rsp_data_s = '0;
               end
            end else if (timeout_s) begin
               state_s    = ST_RESP;
               rsp_code_s = CODE_TMO;
               rsp_data_s = '0;
               rsp_n_s    = hp_n;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      in_flight_s = (state_s == ST_ISSUE) || (state_s == ST_WAIT);
      hp_start_s  = (state_s == ST_ISSUE);
      rsp_valid_s = (state_s == ST_RESP);
      if (in_flight_s) begin
         hp_instr_s = op_s;
         hp_key_s   = key_s;
      end else begin
         hp_instr_s = 2'b00;
         hp_key_s   = '0;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         op_r        <= 2'b00;
         key_r       <= '0;
         run_r       <= 1'b0;
         hp_start_r  <= 1'b0;
         hp_instr_r  <= 2'b00;
         hp_key_r    <= '0;
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= '0;
         rsp_code_r  <= 2'b00;
         rsp_n_r     <= '0;
      end else begin
         state_r     <= state_s;
         op_r        <= op_s;
         key_r       <= key_s;
         run_r       <= 1'b1;
         hp_start_r  <= hp_start_s;
         hp_instr_r  <= hp_instr_s;
         hp_key_r    <= hp_key_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_data_r  <= rsp_data_s;
         rsp_code_r  <= rsp_code_s;
         rsp_n_r     <= rsp_n_s;
      end
   end

   assign cmd_ready      = cmd_ready_s;
   assign hp_start       = hp_start_r;
   assign hp_instruction = hp_instr_r;
   assign hp_key         = hp_key_r;
   assign rsp_valid      = rsp_valid_r;
   assign rsp_data       = rsp_data_r;
   assign rsp_code       = rsp_code_r;
   assign rsp_n          = rsp_n_r;

endmodule

// File: tb/tb_heap_cmd_issuer.sv
// Directed self-checking bench for heap_cmd_issuer; the watchdog case runs only
// when HEAP_CMD_TIMEOUT_EN is defined (TIMEOUT_CYCLES overridden to 16).
module tb_heap_cmd_issuer;
   localparam int KEY_W = 32;
   localparam int N_W   = 10;

   logic             clk;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [KEY_W-1:0] cmd_key;
   logic             hp_start;
   logic [1:0]       hp_instruction;
   logic [KEY_W-1:0] hp_key;
   logic             hp_done;
   logic [KEY_W-1:0] hp_arr_out;
   logic [N_W-1:0]   hp_n;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [KEY_W-1:0] rsp_data;
   logic [1:0]       rsp_code;
   logic [N_W-1:0]   rsp_n;

   int n_checks  = 0;
   int n_pass    = 0;
   int n_fail    = 0;
   int start_cnt = 0;

   heap_cmd_issuer #(
      .KEY_W(KEY_W), .N_W(N_W), .DEPTH(1023), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_key(cmd_key),
      .hp_start(hp_start), .hp_instruction(hp_instruction), .hp_key(hp_key),
      .hp_done(hp_done), .hp_arr_out(hp_arr_out), .hp_n(hp_n),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_code(rsp_code), .rsp_n(rsp_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // every clock with hp_start high counts as one pulse cycle
   always @(posedge clk) begin
      if (hp_start === 1'b1) start_cnt <= start_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic accept(input logic [1:0] op, input logic [KEY_W-1:0] key);
      cmd_op    = op;
      cmd_key   = key;
      cmd_valid = 1'b1;
      #1;
      chk("cmd_ready_idle", cmd_ready, 1'b1);
      tick;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_key   = 32'h0;
   endtask

   task automatic release_rsp;
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      chk("rsp_valid_drop", rsp_valid, 1'b0);
   endtask

   initial begin
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = 2'b00;
      cmd_key    = 32'h0;
      hp_done    = 1'b0;
      hp_arr_out = 32'h0;
      hp_n       = 10'd0;
      rsp_ready  = 1'b0;
      tick;
      tick;
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_hp_start", hp_start, 1'b0);
      chk("rst_hp_instr", hp_instruction, 2'b00);
      chk("rst_hp_key", hp_key, 32'h0);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk("rst_rsp_code", rsp_code, 2'b00);
      chk("rst_rsp_n", rsp_n, 10'd0);
      reset = 1'b0;
      tick;
      chk("cmd_ready_after_rst", cmd_ready, 1'b1);

      // pop on an empty heap is rejected locally
      hp_n = 10'd0;
      accept(2'b10, 32'h0);
      chk("underflow_valid", rsp_valid, 1'b1);
      chk("underflow_code", rsp_code, 2'b01);
      chk("underflow_data", rsp_data, 32'h0);
      chk("underflow_start", start_cnt, 0);
      chk("underflow_cmd_ready", cmd_ready, 1'b0);
      release_rsp;

      // push, done arrives 4 cycles after start
      hp_n = 10'd3;
      accept(2'b01, 32'h12345678);
      chk("push_start", hp_start, 1'b1);
      chk("push_instr", hp_instruction, 2'b01);
      chk("push_key", hp_key, 32'h12345678);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("push_wait_start", hp_start, 1'b0);
         chk("push_wait_instr", hp_instruction, 2'b01);
         chk("push_wait_key", hp_key, 32'h12345678);
         chk("push_wait_valid", rsp_valid, 1'b0);
      end
      hp_done = 1'b1;
      hp_n    = 10'd4;
      #1;
      chk("push_done_cmd_ready", cmd_ready, 1'b0);
      tick;
      hp_done = 1'b0;
      chk("push_rsp_valid", rsp_valid, 1'b1);
      chk("push_rsp_code", rsp_code, 2'b00);
      chk("push_rsp_data", rsp_data, 32'h0);
      chk("push_rsp_n", rsp_n, 10'd4);
      chk("push_resp_instr", hp_instruction, 2'b00);
      chk("push_resp_key", hp_key, 32'h0);
      chk("push_start_count", start_cnt, 1);
      release_rsp;

      // pop; a done during the start cycle must be ignored
      hp_n       = 10'd5;
      hp_arr_out = 32'h0000_0007;
      accept(2'b10, 32'h0);
      hp_done = 1'b1;
      chk("pop_start", hp_start, 1'b1);
      chk("pop_instr", hp_instruction, 2'b10);
      tick;
      hp_done = 1'b0;
      chk("pop_early_done_ignored", rsp_valid, 1'b0);
      chk("pop_wait_instr", hp_instruction, 2'b10);
      tick;
      chk("pop_wait_valid", rsp_valid, 1'b0);
      hp_done = 1'b1;
      hp_n    = 10'd4;
      tick;
      hp_done = 1'b0;
      hp_n    = 10'd9;
      chk("pop_rsp_valid", rsp_valid, 1'b1);
      chk("pop_rsp_data", rsp_data, 32'h7);
      chk("pop_rsp_code", rsp_code, 2'b00);
      chk("pop_rsp_n", rsp_n, 10'd4);
      chk("pop_start_count", start_cnt, 2);
      for (int i = 0; i < 10; i++) begin
         tick;
         chk("hold_valid", rsp_valid, 1'b1);
         chk("hold_data", rsp_data, 32'h7);
         chk("hold_code", rsp_code, 2'b00);
         chk("hold_n", rsp_n, 10'd4);
         chk("hold_cmd_ready", cmd_ready, 1'b0);
      end
      release_rsp;

      // illegal opcode
      accept(2'b11, 32'hDEAD_BEEF);
      chk("ill_valid", rsp_valid, 1'b1);
      chk("ill_code", rsp_code, 2'b10);
      chk("ill_data", rsp_data, 32'h0);
      chk("ill_start_count", start_cnt, 2);
      release_rsp;

      // push into a full heap
      hp_n = 10'd1023;
      accept(2'b01, 32'h0000_0055);
      chk("ovf_valid", rsp_valid, 1'b1);
      chk("ovf_code", rsp_code, 2'b01);
      chk("ovf_data", rsp_data, 32'h0);
      chk("ovf_n", rsp_n, 10'd1023);
      chk("ovf_instr", hp_instruction, 2'b00);
      chk("ovf_start_count", start_cnt, 2);
      release_rsp;

      // NOP
      hp_n = 10'd6;
      accept(2'b00, 32'h0);
      chk("nop_valid", rsp_valid, 1'b1);
      chk("nop_code", rsp_code, 2'b00);
      chk("nop_n", rsp_n, 10'd6);
      release_rsp;

      // reset while waiting for the controller
      hp_n       = 10'd2;
      hp_arr_out = 32'h0000_1111;
      accept(2'b10, 32'h0);
      tick;
      chk("rstw_instr_before", hp_instruction, 2'b10);
      reset = 1'b1;
      #1;
      chk("rstw_instr", hp_instruction, 2'b00);
      chk("rstw_key", hp_key, 32'h0);
      chk("rstw_start", hp_start, 1'b0);
      chk("rstw_valid", rsp_valid, 1'b0);
      chk("rstw_cmd_ready", cmd_ready, 1'b0);
      tick;
      chk("rstw_valid_held", rsp_valid, 1'b0);
      reset = 1'b0;
      tick;
      chk("rstw_cmd_ready_back", cmd_ready, 1'b1);
      hp_arr_out = 32'hABCD_0001;
      accept(2'b10, 32'h0);
      tick;
      hp_done = 1'b1;
      tick;
      hp_done = 1'b0;
      chk("post_rst_valid", rsp_valid, 1'b1);
      chk("post_rst_data", rsp_data, 32'hABCD_0001);
      chk("post_rst_code", rsp_code, 2'b00);
      chk("post_rst_n", rsp_n, 10'd2);
      chk("post_rst_start_count", start_cnt, 4);
      release_rsp;

`ifdef HEAP_CMD_TIMEOUT_EN
      // controller never answers: watchdog fires after 16 WAIT cycles
      hp_n = 10'd0;
      accept(2'b01, 32'h0000_0042);
      for (int i = 0; i < 16; i++) begin
         tick;
         chk("tmo_waiting", rsp_valid, 1'b0);
      end
      tick;
      chk("tmo_valid", rsp_valid, 1'b1);
      chk("tmo_code", rsp_code, 2'b11);
      chk("tmo_data", rsp_data, 32'h0);
      release_rsp;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/heap_cmd_issuer.md
# heap_cmd_issuer

Command initiator for the heap controller: accepts push/pop requests on a valid/ready command port, drives the controller's `start`/`instruction`/`key` interface, waits for `done`, and returns the popped key (or status) on a valid/ready response port. Sits between a host-side command source and `heap_control`. It serialises access to the controller with one command in flight. It also rejects underflow, overflow and illegal opcodes locally so they never reach the heap.

## Interface
- `KEY_W`, 32, key/data width
- `N_W`, 10, width of heap occupancy count
- `DEPTH`, 1023, heap capacity; a push is rejected when `hp_n == DEPTH`
- `TIMEOUT_CYCLES`, 4096, WAIT-state limit (used only with `HEAP_CMD_TIMEOUT_EN`)

- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: issuer can accept a command
- `cmd_op` in 2: 00 NOP, 01 push, 10 pop, 11 illegal
- `cmd_key` in KEY_W: push key
- `hp_start` out 1: start pulse to controller
- `hp_instruction` out 2: opcode to controller
- `hp_key` out KEY_W: key to controller
- `hp_done` in 1: controller completion
- `hp_arr_out` in KEY_W: controller result (root on pop)
- `hp_n` in N_W: controller occupancy
- `rsp_valid` out 1: response present
- `rsp_ready` in 1: response consumed
- `rsp_data` out KEY_W: popped key; 0 for push, NOP and errors
- `rsp_code` out 2: 00 ok, 01 rejected (underflow/overflow), 10 illegal op, 11 timeout
- `rsp_n` out N_W: `hp_n` sampled at completion

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `cmd_ready = 1` only while in IDLE and `hp_done == 0`.
  - On `cmd_valid && cmd_ready`, latch op and key, then check them against the current `hp_n`:
    - op 00 -> RESP, code 00.
    - op 11 -> RESP, code 10.
    - pop with `hp_n == 0`, or push with `hp_n == DEPTH` -> RESP, code 01, controller untouched.
    - otherwise -> ISSUE.
- **ISSUE**
  - `hp_start = 1` for exactly this one cycle.
  - `hp_instruction` and `hp_key` come from latched values and stay stable from ISSUE until leaving WAIT.
  - Always -> WAIT.
- **WAIT**
  - On the first cycle with `hp_done == 1`:
    - capture `rsp_data` (`hp_arr_out` for pop, 0 for push);
    - capture `rsp_n = hp_n`;
    - code 00;
    - -> RESP.
  - `hp_done` high in the same cycle as the ISSUE `hp_start` is ignored. Only WAIT samples it.
- **RESP**
  - `rsp_valid = 1`; `rsp_data`, `rsp_code` and `rsp_n` are held stable.
  - On `rsp_ready` -> IDLE, and `rsp_valid` drops the next cycle.
- Outside ISSUE/WAIT, `hp_instruction = 00` and `hp_key = 0`.
- Width rules: `hp_n` is compared unsigned against `DEPTH` at full N_W; no arithmetic on keys.

## Timing
- Reset values: state IDLE; all outputs 0 (`cmd_ready` rises in the first cycle after reset deassert if `hp_done == 0`).
- Reset asserted mid-operation: immediate return to IDLE, in-flight command and pending response discarded, `hp_start` low.
- Accepted legal command: ISSUE at cycle +1, WAIT from +2, RESP the cycle after `hp_done` is seen. Minimum latency accept -> `rsp_valid` is 3 cycles.
- Locally resolved command (NOP, illegal, rejected): `rsp_valid` at cycle +1.
- Throughput: one command per (latency + response handshake). No new command is accepted while `rsp_valid` is high.
- Outputs are registered. `cmd_ready` is combinational from state and `hp_done` only.

## Configuration
- `HEAP_CMD_TIMEOUT_EN` defined:
  - A WAIT-state counter (cleared on entering WAIT) forces RESP with code 11, `rsp_data = 0`, after `TIMEOUT_CYCLES` cycles without `hp_done`.
  - The controller is not reset by the issuer.
- Not defined: no counter; WAIT holds indefinitely; code 11 is never produced.

## Test plan
- Reset, `hp_n = 0`, pop (op 10) -> `rsp_valid` 1 cycle after accept, code 01, `hp_start` never asserted.
- Push key 0x12345678 with `hp_n = 3`, model `hp_done` 4 cycles after start -> exactly one `hp_start` pulse; `hp_instruction = 01` and `hp_key = 0x12345678` stable until done; response code 00, data 0.
- Pop with `hp_n = 5`, model returns 0x0000_0007 -> `rsp_data = 7`, code 00, `rsp_n` equals `hp_n` at done.
- Hold `rsp_ready = 0` for 10 cycles, then assert it -> response held stable throughout and `cmd_ready` stays 0. Then:
  - op 11 -> code 10;
  - push with `hp_n = DEPTH` -> code 01.
- Assert `reset` during WAIT -> all outputs 0 next cycle, a later pop completes normally. With `HEAP_CMD_TIMEOUT_EN` and `TIMEOUT_CYCLES = 16`, a `hp_done` that never arrives -> code 11 after 16 WAIT cycles.
